pwm_multi_ch: RTL and testbench

PWM_MULTI_CH -- requirements
Module: pwm_multi_ch

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_deadtime.sv | 53 +++++
 rtl/pwm_multi_ch.sv | 165 ++++++++++++++++
 tb/tb_pwm_multi_ch.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared state encoding and default parameters for the multi-channel PWM block.
package pwm_pkg;

   localparam int unsigned NUM_CH_DEF      = 4;
   localparam int unsigned CNT_W_DEF       = 16;
   localparam int unsigned BURST_W_DEF     = 8;
   localparam int unsigned DEAD_CYCLES_DEF = 2;

   typedef logic [0:0] pwm_state_t;

   localparam pwm_state_t IDLE = 1'b0;
   localparam pwm_state_t RUN  = 1'b1;

endpackage

// File: rtl/pwm_deadtime.sv
// One channel of dead-time insertion. Takes the next-cycle raw level and run
// flag, so both outputs stay cycle-aligned with the shared counter.
// A level must be held DEAD_CYCLES+1 cycles in RUN before its output asserts,
// so pulses shorter than the dead time are swallowed.
import pwm_pkg::*;

module pwm_deadtime #(
   parameter int unsigned DEAD_CYCLES = DEAD_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic run_d,
   input  logic raw_d,
   output logic out_p,
   output logic out_n
);

   localparam int unsigned HOLD_MAX = DEAD_CYCLES + 1;
   localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

   logic              run_q;
   logic              raw_q;
   logic [HOLD_W-1:0] hold;
   logic [HOLD_W-1:0] hold_d;
   logic              settled_d;

   // Count how long the (run, raw) pair has been stable, saturating at HOLD_MAX.
   always_comb begin
      hold_d = HOLD_W'(1);
      if ((run_d == run_q) && (raw_d == raw_q)) begin
         hold_d = (hold == HOLD_W'(HOLD_MAX)) ? hold : hold + HOLD_W'(1);
      end
      settled_d = (hold_d == HOLD_W'(HOLD_MAX));
   end

   // Register history and the dead-time gated outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q <= 1'b0;
         raw_q <= 1'b0;
         hold  <= '0;
         out_p <= 1'b0;
         out_n <= 1'b0;
      end else begin
         run_q <= run_d;
         raw_q <= raw_d;
         hold  <= hold_d;
         out_p <= run_d && raw_d && settled_d;
         out_n <= run_d && !raw_d && settled_d;
      end
   end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM with a shared period counter, shadowed period/duty with
// boundary-synchronous reload, and optional burst mode.
// Define PWM_DEADTIME_EN to add per-channel dead-time and complementary outputs.
import pwm_pkg::*;

module pwm_multi_ch #(
   parameter int unsigned NUM_CH      = NUM_CH_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned BURST_W     = BURST_W_DEF,
   parameter int unsigned DEAD_CYCLES = DEAD_CYCLES_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [CNT_W-1:0]        period,
   input  logic [NUM_CH*CNT_W-1:0] duty,
   input  logic                    burst_mode,
   input  logic [BURST_W-1:0]      burst_len,
   input  logic                    start,
   input  logic                    load,
   output logic [NUM_CH-1:0]       pwm_out,
   output logic [NUM_CH-1:0]       pwm_out_n,
   output logic                    busy,
   output logic                    period_tick,
   output logic                    burst_done
);

   pwm_state_t              state, state_d;
   logic [CNT_W-1:0]        cnt, cnt_d;
   logic [BURST_W-1:0]      bcnt, bcnt_d;
   logic [CNT_W-1:0]        period_sh, period_sh_d;
   logic [NUM_CH*CNT_W-1:0] duty_sh, duty_sh_d;
   logic [BURST_W-1:0]      blen_sh, blen_sh_d;
   logic                    mode_sh, mode_sh_d;
   logic                    pend, pend_d;
   logic                    wrap;
   logic                    start_ok;
   logic                    run_d;
   logic                    tick_d;
   logic                    done_d;
   logic [NUM_CH-1:0]       raw_d;

   // Next-state, counters, shadows and the pending-load flag.
   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      bcnt_d      = bcnt;
      period_sh_d = period_sh;
      duty_sh_d   = duty_sh;
      blen_sh_d   = blen_sh;
      mode_sh_d   = mode_sh;
      pend_d      = pend;
      wrap        = (cnt == period_sh - CNT_W'(1));
      start_ok    = en && start && (period != '0) &&
                    !(burst_mode && (burst_len == '0));
      case (state)
         IDLE: begin
            cnt_d  = '0;
            pend_d = 1'b0;
            if (start_ok) begin
               state_d     = RUN;
               bcnt_d      = '0;
               period_sh_d = period;
               duty_sh_d   = duty;
               blen_sh_d   = burst_len;
               mode_sh_d   = burst_mode;
            end
         end
         RUN: begin
            if (!en) begin
               state_d = IDLE;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end else if (wrap) begin
               cnt_d  = '0;
               pend_d = 1'b0;
               if (mode_sh && (bcnt + BURST_W'(1) == blen_sh)) begin
                  state_d = IDLE;
               end else begin
                  if (mode_sh) begin
                     bcnt_d = bcnt + BURST_W'(1);
                  end
                  if (pend || load) begin
                     period_sh_d = period;
                     duty_sh_d   = duty;
                  end
               end
            end else begin
               cnt_d = cnt + CNT_W'(1);
               if (load) begin
                  pend_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output levels for the coming cycle, derived from next-cycle state.
   always_comb begin
      run_d  = (state_d == RUN);
      tick_d = run_d && (cnt_d == period_sh_d - CNT_W'(1));
      done_d = tick_d && mode_sh_d && (bcnt_d + BURST_W'(1) == blen_sh_d);
      raw_d  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         raw_d[i] = run_d && (cnt_d < duty_sh_d[i*CNT_W +: CNT_W]);
      end
   end

   // State, counters, shadows and status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         bcnt        <= '0;
         period_sh   <= '0;
         duty_sh     <= '0;
         blen_sh     <= '0;
         mode_sh     <= 1'b0;
         pend        <= 1'b0;
         busy        <= 1'b0;
         period_tick <= 1'b0;
         burst_done  <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         bcnt        <= bcnt_d;
         period_sh   <= period_sh_d;
         duty_sh     <= duty_sh_d;
         blen_sh     <= blen_sh_d;
         mode_sh     <= mode_sh_d;
         pend        <= pend_d;
         busy        <= run_d;
         period_tick <= tick_d;
         burst_done  <= done_d;
      end
   end

`ifdef PWM_DEADTIME_EN
   for (genvar g = 0; g < NUM_CH; g++) begin : g_dt
      pwm_deadtime #(
         .DEAD_CYCLES (DEAD_CYCLES)
      ) u_dt (
         .clk   (clk),
         .rst   (rst),
         .run_d (run_d),
         .raw_d (raw_d[g]),
         .out_p (pwm_out[g]),
         .out_n (pwm_out_n[g])
      );
   end
`else
   // Raw PWM drives the outputs directly when dead-time is not built in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwm_out <= '0;
      end else begin
         pwm_out <= raw_d;
      end
   end

   assign pwm_out_n = '0;
`endif

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: period-position model checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_pwm_multi_ch;

   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 16;
   localparam int BURST_W = 8;
   localparam int DEAD    = 2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    en;
   logic [CNT_W-1:0]        period;
   logic [NUM_CH*CNT_W-1:0] duty;
   logic                    burst_mode;
   logic [BURST_W-1:0]      burst_len;
   logic                    start;
   logic                    load;
   logic [NUM_CH-1:0]       pwm_out;
   logic [NUM_CH-1:0]       pwm_out_n;
   logic                    busy;
   logic                    period_tick;
   logic                    burst_done;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   pwm_multi_ch #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W), .DEAD_CYCLES(DEAD)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .period(period), .duty(duty),
      .burst_mode(burst_mode), .burst_len(burst_len), .start(start), .load(load),
      .pwm_out(pwm_out), .pwm_out_n(pwm_out_n), .busy(busy),
      .period_tick(period_tick), .burst_done(burst_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: where we are inside the current period and how many periods elapsed.
   bit m_run     = 1'b0;
   int m_pos     = 0;
   int m_per     = 0;
   int m_duty [NUM_CH] = '{default: 0};
   int m_blen    = 0;
   bit m_mode    = 1'b0;
   int m_periods = 0;
   bit m_pend    = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_run = 1'b0; m_pos = 0; m_periods = 0; m_pend = 1'b0;
      end else if (!m_run) begin
         if (en && start && period != 0 && !(burst_mode && burst_len == 0)) begin
            m_run = 1'b1; m_pos = 0; m_periods = 0; m_pend = 1'b0;
            m_per = int'(period); m_blen = int'(burst_len); m_mode = burst_mode;
            for (int i = 0; i < NUM_CH; i++) m_duty[i] = int'(duty[i*CNT_W +: CNT_W]);
         end
      end else if (!en) begin
         m_run = 1'b0; m_pend = 1'b0;
      end else if (m_pos == m_per - 1) begin
         m_periods++;
         if (m_mode && m_periods == m_blen) begin
            m_run = 1'b0; m_pend = 1'b0;
         end else begin
            if (m_pend || load) begin
               m_per = int'(period);
               for (int i = 0; i < NUM_CH; i++) m_duty[i] = int'(duty[i*CNT_W +: CNT_W]);
            end
            m_pend = 1'b0; m_pos = 0;
         end
      end else begin
         m_pos++;
         if (load) m_pend = 1'b1;
      end
   end

   logic [NUM_CH-1:0] e_raw, e_p, e_n;
   logic [NUM_CH-1:0] h_raw [0:DEAD] = '{default: '0};
   logic              h_run [0:DEAD] = '{default: 1'b0};

   // Compare every cycle on the falling edge.
   always @(negedge clk) begin
      for (int i = 0; i < NUM_CH; i++) e_raw[i] = m_run && (m_pos < m_duty[i]);
      for (int k = DEAD; k > 0; k--) begin
         h_raw[k] = h_raw[k-1];
         h_run[k] = h_run[k-1];
      end
      h_raw[0] = e_raw;
      h_run[0] = m_run;
`ifdef PWM_DEADTIME_EN
      for (int i = 0; i < NUM_CH; i++) begin
         e_p[i] = 1'b1; e_n[i] = 1'b1;
         for (int k = 0; k <= DEAD; k++) begin
            if (!(h_run[k] && h_raw[k][i]))  e_p[i] = 1'b0;
            if (!(h_run[k] && !h_raw[k][i])) e_n[i] = 1'b0;
         end
      end
`else
      e_p = e_raw;
      e_n = '0;
`endif
      if (chk_on) begin
         chk("m_pwm", 32'(pwm_out), 32'(e_p));
         chk("m_pwm_n", 32'(pwm_out_n), 32'(e_n));
         chk("m_busy", 32'(busy), 32'(m_run));
         chk("m_tick", 32'(period_tick), 32'(m_run && m_pos == m_per - 1));
         chk("m_done", 32'(burst_done),
             32'(m_run && m_pos == m_per - 1 && m_mode && m_periods + 1 == m_blen));
      end
   end

   // Per-cycle capture for literal checks; index c = c-th cycle after start.
   logic [NUM_CH-1:0] obs_pwm  [1:64];
   logic              obs_tick [1:64];
   logic              obs_done [1:64];
   logic              obs_busy [1:64];
   logic [CNT_W-1:0]        nper;
   logic [NUM_CH*CNT_W-1:0] nduty;

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_obs(input int n, input int load_at, input int en_off_at);
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         obs_pwm[c] = pwm_out; obs_tick[c] = period_tick;
         obs_done[c] = burst_done; obs_busy[c] = busy;
         if (c == load_at) begin
            load = 1'b1; period = nper; duty = nduty;
         end else begin
            load = 1'b0;
         end
         if (c == en_off_at) en = 1'b0;
      end
   endtask

   function automatic int n_hi(input int ch, input int a, input int b);
      int s = 0;
      for (int c = a; c <= b; c++) s += int'(obs_pwm[c][ch]);
      return s;
   endfunction

   function automatic int n_rise(input int ch, input int a, input int b);
      int s = 0;
      for (int c = a + 1; c <= b; c++) if (obs_pwm[c][ch] && !obs_pwm[c-1][ch]) s++;
      if (obs_pwm[a][ch]) s++;
      return s;
   endfunction

   function automatic int n_tick(input int a, input int b);
      int s = 0;
      for (int c = a; c <= b; c++) s += int'(obs_tick[c]);
      return s;
   endfunction

   function automatic int n_done(input int a, input int b);
      int s = 0;
      for (int c = a; c <= b; c++) s += int'(obs_done[c]);
      return s;
   endfunction

   function automatic int n_busy(input int a, input int b);
      int s = 0;
      for (int c = a; c <= b; c++) s += int'(obs_busy[c]);
      return s;
   endfunction

   initial begin
      rst = 1'b0; en = 1'b0; start = 1'b0; load = 1'b0; period = '0; duty = '0;
      burst_mode = 1'b0; burst_len = '0; nper = '0; nduty = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pwm", 32'(pwm_out), 32'd0);
      chk("rst_tick", 32'(period_tick), 32'd0);
      chk("rst_done", 32'(burst_done), 32'd0);
      rst = 1'b1;
      chk_on = 1'b1;

      // Continuous, duties 0/5/10/25 over period 20.
      period = 16'd20; duty = {16'd25, 16'd10, 16'd5, 16'd0}; en = 1'b1; burst_mode = 1'b0;
      do_start();
      run_obs(40, 0, 0);
`ifndef PWM_DEADTIME_EN
      chk("cont_ch0_hi", 32'(n_hi(0, 1, 20)), 32'd0);
      chk("cont_ch1_hi", 32'(n_hi(1, 1, 20)), 32'd5);
      chk("cont_ch2_hi", 32'(n_hi(2, 1, 20)), 32'd10);
      chk("cont_ch3_hi", 32'(n_hi(3, 1, 20)), 32'd20);
      chk("cont_ch1_c1", 32'(obs_pwm[1][1]), 32'd1);
      chk("cont_ch1_c6", 32'(obs_pwm[6][1]), 32'd0);
`endif
      chk("cont_tick_n", 32'(n_tick(1, 40)), 32'd2);
      chk("cont_tick20", 32'(obs_tick[20]), 32'd1);
      chk("cont_done_n", 32'(n_done(1, 40)), 32'd0);
      en = 1'b0;
      @(negedge clk);
      chk("cont_stop_busy", 32'(busy), 32'd0);

      // Burst of 3 periods of 10, duty 4.
      en = 1'b1; burst_mode = 1'b1; burst_len = 8'd3; period = 16'd10; duty = {4{16'd4}};
      do_start();
      run_obs(35, 0, 0);
`ifndef PWM_DEADTIME_EN
      chk("burst_hi", 32'(n_hi(0, 1, 35)), 32'd12);
      chk("burst_rise", 32'(n_rise(0, 1, 35)), 32'd3);
`endif
      chk("burst_done_n", 32'(n_done(1, 35)), 32'd1);
      chk("burst_done30", 32'(obs_done[30]), 32'd1);
      chk("burst_busy30", 32'(obs_busy[30]), 32'd1);
      chk("burst_busy31", 32'(obs_busy[31]), 32'd0);

      // Reload mid-period: 10/2 then 8/6.
      burst_mode = 1'b0; period = 16'd10; duty = {4{16'd2}};
      nper = 16'd8; nduty = {4{16'd6}};
      do_start();
      run_obs(26, 5, 0);
`ifndef PWM_DEADTIME_EN
      chk("reload_old_hi", 32'(n_hi(0, 1, 10)), 32'd2);
      chk("reload_new_hi", 32'(n_hi(0, 11, 18)), 32'd6);
`endif
      chk("reload_tick10", 32'(obs_tick[10]), 32'd1);
      chk("reload_tick_mid", 32'(n_tick(11, 17)), 32'd0);
      chk("reload_tick18", 32'(obs_tick[18]), 32'd1);
      chk("reload_tick26", 32'(obs_tick[26]), 32'd1);
      en = 1'b0;
      @(negedge clk);

      // Abort a 3x10 burst at cycle 15, then restart.
      en = 1'b1; burst_mode = 1'b1; burst_len = 8'd3; period = 16'd10; duty = {4{16'd6}};
      do_start();
      run_obs(35, 0, 15);
`ifndef PWM_DEADTIME_EN
      chk("abort_pwm15", 32'(obs_pwm[15][0]), 32'd1);
`endif
      chk("abort_pwm16", 32'(obs_pwm[16]), 32'd0);
      chk("abort_busy16", 32'(obs_busy[16]), 32'd0);
      chk("abort_done_n", 32'(n_done(1, 35)), 32'd0);
      en = 1'b1;
      do_start();
      run_obs(12, 0, 0);
`ifndef PWM_DEADTIME_EN
      chk("restart_pwm1", 32'(obs_pwm[1][0]), 32'd1);
      chk("restart_pwm7", 32'(obs_pwm[7][0]), 32'd0);
`endif
      chk("restart_busy1", 32'(obs_busy[1]), 32'd1);
      chk("restart_tick_early", 32'(n_tick(1, 9)), 32'd0);
      chk("restart_tick10", 32'(obs_tick[10]), 32'd1);
      en = 1'b0;
      @(negedge clk);

      // Asynchronous reset mid-run, then a zero-length burst start.
      en = 1'b1; burst_mode = 1'b0; period = 16'd20; duty = {16'd25, 16'd10, 16'd5, 16'd0};
      do_start();
      run_obs(7, 0, 0);
      @(posedge clk);
      #2;
      chk("prerst_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      chk("arst_pwm", 32'(pwm_out), 32'd0);
      chk("arst_pwm_n", 32'(pwm_out_n), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_tick", 32'(period_tick), 32'd0);
      chk("arst_done", 32'(burst_done), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      burst_mode = 1'b1; burst_len = 8'd0; period = 16'd10;
      do_start();
      run_obs(5, 0, 0);
      chk("zero_len_busy", 32'(n_busy(1, 5)), 32'd0);

      en = 1'b0;
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
